sync_launch: RTL and testbench

//  Source-side transmitter for the clkA->clkB strobe/data crossing. Accepts a word on a

---
 rtl/sync_launch_pkg.sv | 23 ++
 rtl/sync_launch_if.sv | 22 ++
 rtl/sync_launch_sync_2ff.sv | 22 ++
 rtl/sync_launch.sv | 127 ++++++++++++
 tb/tb_sync_launch.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/sync_launch_pkg.sv
// Shared types and defaults for the clkA->clkB strobe/data launcher.
package sync_launch_pkg;

  localparam int unsigned DEF_N        = 8;
  localparam int unsigned DEF_STB_CYC  = 4;
  localparam int unsigned DEF_HOLD_CYC = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StAckLow
  } state_e;

  // Counter must reach max(STB_CYC, HOLD_CYC) - 1 without wrapping.
  function automatic int unsigned cnt_width(int unsigned stb_cyc, int unsigned hold_cyc);
    int unsigned m;
    m = (stb_cyc > hold_cyc) ? stb_cyc : hold_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_launch_if.sv
// Source-side valid/ready port plus the held crossing bus, strobe and status flags.
interface sync_launch_if #(
  parameter int unsigned N = sync_launch_pkg::DEF_N
);
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] data_out;
  logic         stb;
  logic         busy;
  logic         done;

  modport master (
    output in_data, in_valid,
    input  in_ready, data_out, stb, busy, done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, data_out, stb, busy, done
  );
endinterface

// File: rtl/sync_launch_sync_2ff.sv
// Two-stage synchronizer bringing the receiver acknowledge into clkA.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/sync_launch.sv
// Strobe/data launcher for the clkA->clkB crossing; data is held stable around the strobe.
// SYNC_LAUNCH_ACK_EN selects a four-phase ack handshake instead of fixed strobe/hold timing.
module sync_launch
  import sync_launch_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned STB_CYC  = DEF_STB_CYC,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic          clkA,
  input  logic          rst,
  input  logic          ena,
  sync_launch_if.slave  bus,
  input  logic          ack_async
);

  localparam int unsigned CW = cnt_width(STB_CYC, HOLD_CYC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

  state_e       state_q;
  logic [N-1:0] data_q;
  logic         stb_q;
  logic         busy_q;
  logic         done_q;
  logic [CW-1:0] cnt_q;

`ifdef SYNC_LAUNCH_ACK_EN
  logic ack_s;

  // Free-running so the synchronizer never holds a stale ack across an ena gap.
  sync_2ff u_ack_sync (
    .clk (clkA),
    .rst (rst),
    .d   (ack_async),
    .q   (ack_s)
  );
`else
  localparam logic [CW-1:0] STB_LAST = CW'(STB_CYC - 1);
  logic unused_ack;
  assign unused_ack = ack_async;
`endif

  assign bus.in_ready = ena & (state_q == StIdle);
  assign bus.data_out = data_q;
  assign bus.stb      = stb_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  always_ff @(posedge clkA) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (ena) begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            data_q  <= bus.in_data;
            busy_q  <= 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
`ifdef SYNC_LAUNCH_ACK_EN
          // A leftover ack from the previous transfer must clear before strobing.
          if (!ack_s) begin
            stb_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= StStrobe;
          end
`else
          stb_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= StStrobe;
`endif
        end
        StStrobe: begin
`ifdef SYNC_LAUNCH_ACK_EN
          if (ack_s) begin
            stb_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StAckLow;
          end
`else
          if (cnt_q == STB_LAST) begin
            stb_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StHold: begin
          if (cnt_q == HOLD_LAST) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef SYNC_LAUNCH_ACK_EN
        StAckLow: begin
          if (!ack_s) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
`endif
        default: begin
          stb_q   <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_launch.sv
// Bench for sync_launch: timeline model of each transfer plus directed literal checks.
module tb_sync_launch;
  localparam int unsigned N    = 8;
  localparam int unsigned STB  = 4;
  localparam int unsigned HOLD = 4;

  logic clkA = 1'b0;
  logic rst  = 1'b1;
  logic ena  = 1'b0;
  logic ack_async = 1'b0;

  sync_launch_if #(.N(N)) bus ();

  sync_launch #(
    .N        (N),
    .STB_CYC  (STB),
    .HOLD_CYC (HOLD)
  ) dut (
    .clkA      (clkA),
    .rst       (rst),
    .ena       (ena),
    .bus       (bus.slave),
    .ack_async (ack_async)
  );

  always #5 clkA = ~clkA;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: a transfer is a timeline counted in enabled edges since its accept edge.
  bit           m_active;
  int           m_age;
  logic [N-1:0] m_data;
  bit           m_done;
  int           m_done_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clkA);
    #2;
  endtask

  initial begin : model_and_compare
    bit exp_stb;
    m_active = 0; m_age = 0; m_data = '0; m_done = 0; m_done_cnt = 0;
    forever begin
      @(posedge clkA);
      if (rst) begin
        m_active = 0; m_age = 0; m_data = '0; m_done = 0;
      end else if (ena) begin
        m_done = 0;
        if (m_active) begin
          m_age++;
          if (m_age == 1 + STB + HOLD) begin
            m_active = 0;
            m_done   = 1;
            m_done_cnt++;
          end
        end else if (bus.in_valid) begin
          m_active = 1;
          m_age    = 0;
          m_data   = bus.in_data;
        end
      end
      #1;
      exp_stb = m_active && (m_age >= 1) && (m_age <= STB);
      check("data_out", bus.data_out, m_data);
      check("stb",      bus.stb,      exp_stb);
      check("busy",     bus.busy,     m_active);
      check("done",     bus.done,     m_done);
      check("in_ready", bus.in_ready, ena && !m_active);
    end
  end

  initial begin : stim
    bit [9:0] stb_v;
    bit [9:0] done_v;
    int       n;
    int       n_hi;
    int       d0;

    // Reset holds everything low even with in_valid asserted.
    bus.in_valid = 1'b1; bus.in_data = 8'hFF; rst = 1'b1; ena = 1'b1;
    tick(); tick();
    check("rst_data_out", bus.data_out, 0);
    check("rst_stb",      bus.stb,      0);
    check("rst_busy",     bus.busy,     0);
    check("rst_done",     bus.done,     0);

    // Single transfer of A5: exact strobe and done shape.
    rst = 1'b0; bus.in_data = 8'hA5; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    stb_v[0] = bus.stb; done_v[0] = bus.done;
    for (int i = 1; i < 10; i++) begin
      tick();
      stb_v[i] = bus.stb; done_v[i] = bus.done;
      check("a5_data_held", bus.data_out, 8'hA5);
    end
    check("a5_stb_shape",  stb_v,  10'b0000011110);
    check("a5_done_shape", done_v, 10'b1000000000);
    check("a5_in_ready",   bus.in_ready, 1);

    // Back-to-back: second word accepted on the edge after done.
    bus.in_data = 8'h11; bus.in_valid = 1'b1;
    tick();
    check("b2b_first", bus.data_out, 8'h11);
    bus.in_data = 8'h22;
    n = 0;
    while (bus.data_out !== 8'h22 && n < 40) begin
      tick();
      n++;
    end
    check("b2b_gap", n, 10);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("b2b_done2", bus.done, 1);
    check("b2b_data2", bus.data_out, 8'h22);

    // ena low mid-strobe freezes the strobe; total enabled strobe cycles stay 4.
    tick();
    bus.in_data = 8'h3C; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_hi = 0;
    tick(); if (bus.stb) n_hi++;
    tick(); if (bus.stb) n_hi++;
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_stb", bus.stb, 1);
    end
    ena = 1'b1;
    n = 0;
    do begin
      tick();
      if (bus.stb) n_hi++;
      n++;
    end while (bus.stb && n < 20);
    check("freeze_stb_total", n_hi, 4);
    n = 0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    check("freeze_done_seen", bus.done, 1);

    // Reset during HOLD aborts without a done pulse, then a fresh transfer works.
    tick();
    bus.in_data = 8'h5A; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    d0 = m_done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("hold_rst_stb",  bus.stb,      0);
    check("hold_rst_data", bus.data_out, 0);
    check("hold_rst_busy", bus.busy,     0);
    check("hold_rst_done", bus.done,     0);
    for (int i = 0; i < 6; i++) tick();
    check("hold_rst_no_done", m_done_cnt - d0, 0);
    bus.in_data = 8'h77; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("post_rst_done", bus.done, 1);
    check("post_rst_data", bus.data_out, 8'h77);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(99) == 0);
      ena          = ($urandom_range(99) < 85);
      bus.in_valid = $urandom_range(1);
      bus.in_data  = N'($urandom);
      tick();
    end
    rst = 1'b0; ena = 1'b1; bus.in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
